// File: rtl/axil_regfile.sv
`default_nettype none
// ============================================================================
// axil_regfile : AXI4-Lite register bank with byte strobes and SLVERR decode
// Revision     : 1.0
// ============================================================================
module axil_regfile #(
  parameter int          ADDR_WIDTH  = 12,
  parameter int          NUM_REGS    = 16,
  parameter logic [31:0] RESET_VALUE = 32'h0
) (
  input  logic                     axil_aclk,
  input  logic                     axil_aresetn,

  input  logic [ADDR_WIDTH-1:0]    s_axil_awaddr,
  input  logic [2:0]               s_axil_awprot,
  input  logic                     s_axil_awvalid,
  output logic                     s_axil_awready,

  input  logic [31:0]              s_axil_wdata,
  input  logic [3:0]               s_axil_wstrb,
  input  logic                     s_axil_wvalid,
  output logic                     s_axil_wready,

  output logic [1:0]               s_axil_bresp,
  output logic                     s_axil_bvalid,
  input  logic                     s_axil_bready,

  input  logic [ADDR_WIDTH-1:0]    s_axil_araddr,
  input  logic [2:0]               s_axil_arprot,
  input  logic                     s_axil_arvalid,
  output logic                     s_axil_arready,

  output logic [31:0]              s_axil_rdata,
  output logic [1:0]               s_axil_rresp,
  output logic                     s_axil_rvalid,
  input  logic                     s_axil_rready,

  output logic [32*NUM_REGS-1:0]   reg_out,
  output logic [NUM_REGS-1:0]      reg_wr_stb
);

  localparam int          c_idx_w       = ADDR_WIDTH - 2;
  localparam logic [31:0] c_num_regs    = 32'(NUM_REGS);
  localparam logic [1:0]  c_resp_okay   = 2'b00;
  localparam logic [1:0]  c_resp_slverr = 2'b10;

  logic                aw_full_q, aw_full_d;
  logic [c_idx_w-1:0]  aw_idx_q,  aw_idx_d;
  logic                w_full_q,  w_full_d;
  logic [31:0]         wdata_q,   wdata_d;
  logic [3:0]          wstrb_q,   wstrb_d;
  logic                bvalid_q,  bvalid_d;
  logic [1:0]          bresp_q,   bresp_d;
  logic                rvalid_q,  rvalid_d;
  logic [31:0]         rdata_q,   rdata_d;
  logic [1:0]          rresp_q,   rresp_d;
  logic [NUM_REGS-1:0] wr_stb_q,  wr_stb_d;
  logic [31:0]         regs_q [NUM_REGS];
  logic [31:0]         regs_d [NUM_REGS];

  logic                aw_hs;
  logic                w_hs;
  logic                ar_hs;
  logic                commit;
  logic                aw_in_range;
  logic                ar_in_range;
  logic [c_idx_w-1:0]  ar_idx;
  logic [31:0]         rd_word;
  logic                unused_bits;

  // Protection bits and the byte offset inside a word carry no meaning here.
  assign unused_bits = ^{s_axil_awprot, s_axil_arprot,
                         s_axil_awaddr[1:0], s_axil_araddr[1:0]};

  assign s_axil_awready = !aw_full_q && !bvalid_q;
  assign s_axil_wready  = !w_full_q && !bvalid_q;
  assign s_axil_arready = !rvalid_q;

  assign aw_hs  = s_axil_awvalid && s_axil_awready;
  assign w_hs   = s_axil_wvalid && s_axil_wready;
  assign ar_hs  = s_axil_arvalid && s_axil_arready;
  assign commit = aw_full_q && w_full_q && !bvalid_q;

  assign ar_idx      = s_axil_araddr[ADDR_WIDTH-1:2];
  assign aw_in_range = 32'(aw_idx_q) < c_num_regs;
  assign ar_in_range = 32'(ar_idx) < c_num_regs;

  // Write channel: independent AW/W holding slots, drained by a single commit.
  always_comb begin
    aw_full_d = aw_full_q;
    aw_idx_d  = aw_idx_q;
    w_full_d  = w_full_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;

    if (aw_hs) begin
      aw_full_d = 1'b1;
      aw_idx_d  = s_axil_awaddr[ADDR_WIDTH-1:2];
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      wdata_d  = s_axil_wdata;
      wstrb_d  = s_axil_wstrb;
    end

    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = aw_in_range ? c_resp_okay : c_resp_slverr;
    end else if (bvalid_q && s_axil_bready) begin
      bvalid_d = 1'b0;
    end
  end

  // Out-of-range indices match no register, so they neither write nor strobe.
  always_comb begin
    wr_stb_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (commit && (32'(aw_idx_q) == 32'(i))) begin
        wr_stb_d[i] = 1'b1;
        for (int b = 0; b < 4; b++) begin
          if (wstrb_q[b]) begin
            regs_d[i][8*b +: 8] = wdata_q[8*b +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (32'(ar_idx) == 32'(i)) begin
        rd_word = regs_q[i];
      end
    end
  end

  // Read capture samples regs_q, so a same-edge commit is not yet visible.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_word;
      rresp_d  = ar_in_range ? c_resp_okay : c_resp_slverr;
    end else if (rvalid_q && s_axil_rready) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge axil_aclk or negedge axil_aresetn) begin
    if (!axil_aresetn) begin
      aw_full_q <= 1'b0;
      aw_idx_q  <= '0;
      w_full_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= c_resp_okay;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= c_resp_okay;
      wr_stb_q  <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= RESET_VALUE;
      end
    end else begin
      aw_full_q <= aw_full_d;
      aw_idx_q  <= aw_idx_d;
      w_full_q  <= w_full_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      wr_stb_q  <= wr_stb_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign s_axil_bvalid = bvalid_q;
  assign s_axil_bresp  = bresp_q;
  assign s_axil_rvalid = rvalid_q;
  assign s_axil_rdata  = rdata_q;
  assign s_axil_rresp  = rresp_q;
  assign reg_wr_stb    = wr_stb_q;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg_out
    assign reg_out[32*i +: 32] = regs_q[i];
  end

endmodule

`default_nettype wire

// File: tb/tb_axil_regfile.sv
`default_nettype none
// ============================================================================
// tb_axil_regfile : directed scoreboard bench for axil_regfile
// Revision        : 1.0
// ============================================================================
module tb_axil_regfile;

  localparam int          ADDR_WIDTH  = 12;
  localparam int          NUM_REGS    = 16;
  localparam logic [31:0] RESET_VALUE = 32'h0;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } rexp_t;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [31:0]             wdata;
  logic [3:0]              wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [31:0]             rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;
  logic [32*NUM_REGS-1:0]  reg_out;
  logic [NUM_REGS-1:0]     reg_wr_stb;

  logic [1:0]              exp_b [$];
  rexp_t                   exp_r [$];
  logic [NUM_REGS-1:0]     stb_seen [$];
  logic [31:0]             exp_regs [NUM_REGS];
  int                      n_checks = 0;
  int                      n_fail   = 0;

  always #5 clk = ~clk;

  axil_regfile #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .NUM_REGS    (NUM_REGS),
    .RESET_VALUE (RESET_VALUE)
  ) dut (
    .axil_aclk      (clk),
    .axil_aresetn   (rst_n),
    .s_axil_awaddr  (awaddr),
    .s_axil_awprot  (awprot),
    .s_axil_awvalid (awvalid),
    .s_axil_awready (awready),
    .s_axil_wdata   (wdata),
    .s_axil_wstrb   (wstrb),
    .s_axil_wvalid  (wvalid),
    .s_axil_wready  (wready),
    .s_axil_bresp   (bresp),
    .s_axil_bvalid  (bvalid),
    .s_axil_bready  (bready),
    .s_axil_araddr  (araddr),
    .s_axil_arprot  (arprot),
    .s_axil_arvalid (arvalid),
    .s_axil_arready (arready),
    .s_axil_rdata   (rdata),
    .s_axil_rresp   (rresp),
    .s_axil_rvalid  (rvalid),
    .s_axil_rready  (rready),
    .reg_out        (reg_out),
    .reg_wr_stb     (reg_wr_stb)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_regs(input string name);
    for (int i = 0; i < NUM_REGS; i++) begin
      check($sformatf("%s_reg%0d", name, i), reg_out[32*i +: 32], exp_regs[i]);
    end
  endtask

  // Strobe pulses since the last call; a stretched pulse shows up as two entries.
  task automatic check_stb(input string name, input int exp_n, input logic [NUM_REGS-1:0] exp_v);
    @(negedge clk); #1;
    check({name, "_stb_count"}, 32'(stb_seen.size()), 32'(exp_n));
    if (stb_seen.size() != 0) check({name, "_stb_val"}, 32'(stb_seen[0]), 32'(exp_v));
    stb_seen.delete();
    @(posedge clk); #1;
  endtask

  task automatic push_r(input logic [31:0] data, input logic [1:0] resp);
    rexp_t e;
    e.data = data;
    e.resp = resp;
    exp_r.push_back(e);
  endtask

  task automatic send_aw(input logic [ADDR_WIDTH-1:0] addr);
    int n = 0;
    awaddr  = addr;
    awvalid = 1'b1;
    @(negedge clk);
    while (!awready && n < 100) begin @(negedge clk); n++; end
    if (!awready) check("aw_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb);
    int n = 0;
    wdata  = data;
    wstrb  = strb;
    wvalid = 1'b1;
    @(negedge clk);
    while (!wready && n < 100) begin @(negedge clk); n++; end
    if (!wready) check("w_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    wvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [ADDR_WIDTH-1:0] addr);
    int n = 0;
    araddr  = addr;
    arvalid = 1'b1;
    @(negedge clk);
    while (!arready && n < 100) begin @(negedge clk); n++; end
    if (!arready) check("ar_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic wait_b();
    int n = 0;
    @(negedge clk);
    while (!(bvalid && bready) && n < 100) begin @(negedge clk); n++; end
    if (!(bvalid && bready)) check("b_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_r();
    int n = 0;
    @(negedge clk);
    while (!(rvalid && rready) && n < 100) begin @(negedge clk); n++; end
    if (!(rvalid && rready)) check("r_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic axi_write(input logic [ADDR_WIDTH-1:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] resp);
    exp_b.push_back(resp);
    fork
      send_aw(addr);
      send_w(data, strb);
    join
    wait_b();
  endtask

  task automatic axi_read(input logic [ADDR_WIDTH-1:0] addr, input logic [31:0] data,
                          input logic [1:0] resp);
    push_r(data, resp);
    send_ar(addr);
    wait_r();
  endtask

  task automatic mon_b();
    forever begin
      @(negedge clk);
      if (rst_n && bvalid && bready) begin
        if (exp_b.size() == 0) check("b_unexpected", 32'd1, 32'd0);
        else check("bresp", 32'(bresp), 32'(exp_b.pop_front()));
      end
    end
  endtask

  task automatic mon_r();
    rexp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && rvalid && rready) begin
        if (exp_r.size() == 0) begin
          check("r_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_r.pop_front();
          check("rdata", rdata, e.data);
          check("rresp", 32'(rresp), 32'(e.resp));
        end
      end
    end
  endtask

  task automatic mon_stb();
    forever begin
      @(negedge clk);
      if (reg_wr_stb != '0) stb_seen.push_back(reg_wr_stb);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; awaddr = '0; awprot = 3'b0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
    araddr = '0; arprot = 3'b0; arvalid = 1'b0; rready = 1'b1;
    for (int i = 0; i < NUM_REGS; i++) exp_regs[i] = RESET_VALUE;
    fork
      mon_b();
      mon_r();
      mon_stb();
    join_none

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle after reset
    @(negedge clk);
    check("rst_awready", 32'(awready), 32'd1);
    check("rst_wready",  32'(wready),  32'd1);
    check("rst_arready", 32'(arready), 32'd1);
    check("rst_bvalid",  32'(bvalid),  32'd0);
    check("rst_rvalid",  32'(rvalid),  32'd0);
    check("rst_stb",     32'(reg_wr_stb), 32'd0);
    check_regs("rst");
    @(posedge clk); #1;
    axi_read(12'h000, 32'h0000_0000, RESP_OKAY);

    // Full-word write and readback
    axi_write(12'h008, 32'h99aa_bbcc, 4'hF, RESP_OKAY);
    exp_regs[2] = 32'h99aa_bbcc;
    check_stb("wr008", 1, 16'h0004);
    check("reg_out_2", reg_out[95:64], 32'h99aa_bbcc);
    axi_read(12'h008, 32'h99aa_bbcc, RESP_OKAY);

    // Byte strobes
    axi_write(12'h00C, 32'hddee_ff00, 4'hF, RESP_OKAY);
    check_stb("pre00c", 1, 16'h0008);
    axi_write(12'h00C, 32'h1122_3344, 4'h3, RESP_OKAY);
    exp_regs[3] = 32'hddee_3344;
    check_stb("strb3", 1, 16'h0008);
    axi_read(12'h00C, 32'hddee_3344, RESP_OKAY);
    axi_write(12'h00C, 32'hffff_ffff, 4'h0, RESP_OKAY);
    check_stb("strb0", 1, 16'h0008);
    check_regs("strb0");
    axi_read(12'h00C, 32'hddee_3344, RESP_OKAY);

    // W five cycles ahead of AW: commit one edge after the AW handshake
    exp_b.push_back(RESP_OKAY);
    send_w(32'h55aa_1234, 4'hF);
    @(negedge clk);
    check("w_held_wready", 32'(wready), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    send_aw(12'h014);
    @(negedge clk);
    check("wfirst_b_before", 32'(bvalid), 32'd0);
    @(negedge clk);
    check("wfirst_b_commit", 32'(bvalid), 32'd1);
    exp_regs[5] = 32'h55aa_1234;
    check("wfirst_reg5", reg_out[191:160], 32'h55aa_1234);
    check_stb("wfirst", 1, 16'h0020);

    // B backpressure
    bready = 1'b0;
    exp_b.push_back(RESP_OKAY);
    fork
      send_aw(12'h018);
      send_w(32'hcafe_f00d, 4'hF);
    join
    @(posedge clk);
    repeat (4) begin
      @(negedge clk);
      check("bp_bvalid",  32'(bvalid),  32'd1);
      check("bp_bresp",   32'(bresp),   32'(RESP_OKAY));
      check("bp_awready", 32'(awready), 32'd0);
      check("bp_wready",  32'(wready),  32'd0);
    end
    @(posedge clk); #1;
    bready = 1'b1;
    wait_b();
    exp_regs[6] = 32'hcafe_f00d;
    check_stb("bp", 1, 16'h0040);

    // R backpressure
    rready = 1'b0;
    push_r(32'hcafe_f00d, RESP_OKAY);
    send_ar(12'h018);
    repeat (3) begin
      @(negedge clk);
      check("rbp_rvalid",  32'(rvalid),  32'd1);
      check("rbp_rdata",   rdata,        32'hcafe_f00d);
      check("rbp_arready", 32'(arready), 32'd0);
    end
    @(posedge clk); #1;
    rready = 1'b1;
    wait_r();

    // Out of range and unaligned
    axi_write(12'h040, 32'hffff_ffff, 4'hF, RESP_SLVERR);
    check_stb("oor", 0, 16'h0000);
    check_regs("oor");
    axi_read(12'h040, 32'h0000_0000, RESP_SLVERR);
    axi_read(12'h00B, 32'h99aa_bbcc, RESP_OKAY);

    // Read capture and write commit on the same edge to index 1
    axi_write(12'h004, 32'h1111_1111, 4'hF, RESP_OKAY);
    check_stb("pre004", 1, 16'h0002);
    exp_b.push_back(RESP_OKAY);
    push_r(32'h1111_1111, RESP_OKAY);
    fork
      send_aw(12'h004);
      send_w(32'h2222_2222, 4'hF);
    join
    send_ar(12'h004);
    fork
      wait_b();
      wait_r();
    join
    exp_regs[1] = 32'h2222_2222;
    check_stb("coll", 1, 16'h0002);
    axi_read(12'h004, 32'h2222_2222, RESP_OKAY);

    // Reset with B pending and an AW presented
    bready = 1'b0;
    exp_b.push_back(RESP_OKAY);
    fork
      send_aw(12'h010);
      send_w(32'h0bad_f00d, 4'hF);
    join
    @(posedge clk); #1;
    awaddr  = 12'h014;
    awvalid = 1'b1;
    @(negedge clk);
    check("prerst_bvalid", 32'(bvalid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_bvalid",  32'(bvalid),  32'd0);
    check("arst_bresp",   32'(bresp),   32'd0);
    check("arst_awready", 32'(awready), 32'd1);
    check("arst_wready",  32'(wready),  32'd1);
    check("arst_arready", 32'(arready), 32'd1);
    check("arst_rvalid",  32'(rvalid),  32'd0);
    check("arst_rdata",   rdata,        32'd0);
    check("arst_stb",     32'(reg_wr_stb), 32'd0);
    for (int i = 0; i < NUM_REGS; i++) exp_regs[i] = RESET_VALUE;
    check_regs("arst");
    awvalid = 1'b0;
    bready  = 1'b1;
    exp_b.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    stb_seen.delete();
    repeat (3) @(negedge clk);
    check("postrst_bvalid", 32'(bvalid), 32'd0);
    check_regs("postrst");
    check_stb("postrst", 0, 16'h0000);
    axi_read(12'h010, 32'h0000_0000, RESP_OKAY);
    axi_read(12'h014, 32'h0000_0000, RESP_OKAY);

    repeat (2) @(posedge clk);
    check("exp_b_drained", 32'(exp_b.size()), 32'd0);
    check("exp_r_drained", 32'(exp_r.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
